phased_array_ctrl: RTL
======================

// Module: phased_array_ctrl
// PURPOSE
//   Parametrised transducer-array drive controller, successor to the fixed 4-channel PWM datapath.
//   Parses a byte command stream (from the RX FIFO / receiver path) into a double-buffered bank of
//   per-channel phase, enable and global duty settings. Banks swap atomically on a PWM period boundary.
//   Runs as sync master (free-running) or slave (locked to sync_in) under a parameter.
// PARAMETERS
//   NUM_CHANNELS  16    transducer channels, 1..256
//   CNT_MAX       256   clocks per output period, 2..256 (10.24 MHz / 40 kHz = 256)
//   CNT_W         $clog2(CNT_MAX)  counter/phase width (derived, do not override)
//   MASTER        1     1 = free-run and drive sync_out; 0 = slave to sync_in
// PORTS
//   clk             in   1             single clock; all logic in this domain
//   rst             in   1             asynchronous active-high reset
//   s_data          in   8             command byte
//   s_valid         in   1             s_data valid
//   s_ready         out  1             byte accepted when s_valid && s_ready
//   sync_in         in   1             external period sync (used when MASTER=0), asynchronous
//   sync_out        out  1             period sync to next board
//   trans           out  NUM_CHANNELS  transducer drive outputs
//   period_start    out  1             1-clk pulse on the cycle cnt==0
//   commit_pending  out  1             COMMIT received, swap not yet done
//   cmd_err         out  1             1-clk pulse on rejected frame
// BEHAVIOUR
//   Reset (async, any time incl. mid-frame): cnt=0, parser IDLE, s_ready=1, trans=0, sync_out=0,
//     period_start=0, commit_pending=0, cmd_err=0; shadow+active: phase=0, enable=all 1, duty=CNT_MAX/2.
//   Commands (byte frames, accepted one per handshake):
//     0x01 ch ph  SET_PHASE  shadow_phase[ch]=ph
//     0x02        COMMIT     commit_pending<=1
//     0x03 ch en  SET_ENABLE shadow_en[ch]=en[0]
//     0x04 d      SET_DUTY   shadow_duty=d (global; 9-bit compare, d is 0..255)
//   Parser FSM: IDLE -> ARG1 -> ARG2 -> IDLE (arg count per opcode; COMMIT completes in IDLE).
//   Unknown opcode: cmd_err pulse the cycle after acceptance, stay IDLE, byte dropped.
//   ch>=NUM_CHANNELS or ph>=CNT_MAX: frame consumed, no write, cmd_err pulse after final byte.
//   s_ready=0 while commit_pending=1; shadow cannot change between COMMIT and swap.
//   Counter: cnt 0..CNT_MAX-1, wraps to 0. Boundary = cycle where next cnt is 0.
//   At boundary with commit_pending=1 (registered before this cycle): active<=shadow,
//     commit_pending<=0, s_ready=1 next cycle. COMMIT accepted on the boundary cycle waits one period.
//   MASTER=1: free-run; sync_out registered = (cnt < CNT_MAX/2).
//   MASTER=0: sync_in via 2-flop synchroniser + rising-edge detect. Edge forces next cnt=0
//     (counts as boundary, swap applies). With no edges, free-run. sync_out = synchronised sync_in.
//   Drive: d_i = (cnt - active_phase[i]) mod CNT_MAX (no power-of-2 assumption).
//     trans[i] registered = active_en[i] && (d_i < active_duty). Latency 1 clk from cnt.
//     duty=0 -> channel low; duty>=CNT_MAX -> channel high whenever enabled.
//   period_start registered, asserted the clock after cnt==0 aligns with trans for cnt 0.
// TESTING  (NUM_CHANNELS=4, CNT_MAX=8, MASTER=1 unless stated)
//   Reset, no commands -> all trans high for cnt 0..3 (1-clk lag), low 4..7; sync_out same pattern.
//   01 01 02, 02 -> trans[1] unchanged until boundary, then high for cnt 2..5; ch0/2/3 unchanged.
//   04 00, 02 -> all trans low after boundary; 04 08, 02 -> all trans constant high.
//   7F -> cmd_err 1 pulse, no state change; 01 04 03 -> cmd_err, no write; 03 02 00, 02 -> trans[2]=0.
//   02 then 01 00 05 held valid -> s_ready=0 until boundary, bytes land in shadow after swap only.
//   MASTER=0: sync_in rises at cnt=5 -> cnt=0 within 3 clks, pending commit applied; rst mid-frame -> defaults.

Source files
------------

// File: rtl/phased_array_ctrl.sv
// rtl/phased_array_ctrl.sv - double-buffered phased-array drive controller with byte command parser
module phased_array_ctrl #(
  parameter int NUM_CHANNELS = 16,
  parameter int CNT_MAX      = 256,
  parameter int CNT_W        = $clog2(CNT_MAX),
  parameter bit MASTER       = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    sync_in,
  output logic                    sync_out,
  output logic [NUM_CHANNELS-1:0] trans,
  output logic                    period_start,
  output logic                    commit_pending,
  output logic                    cmd_err
);

  localparam int               CH_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CNT_MAX / 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   CNT_FULL  = (CNT_W + 1)'(CNT_MAX);
  localparam logic [8:0]       NUM_CH_9  = 9'(NUM_CHANNELS);
  localparam logic [8:0]       CNT_MAX_9 = 9'(CNT_MAX);
  localparam logic [7:0]       DUTY_RST  = 8'(CNT_MAX / 2);

  localparam logic [7:0] OP_SET_PHASE = 8'h01;
  localparam logic [7:0] OP_COMMIT    = 8'h02;
  localparam logic [7:0] OP_SET_EN    = 8'h03;
  localparam logic [7:0] OP_SET_DUTY  = 8'h04;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARG1,
    ST_ARG2
  } state_e;

  // Parser state and frame holding registers
  state_e            state_q;
  logic [7:0]        opcode_q;
  logic [7:0]        ch_q;
  logic              commit_pending_q;
  logic              cmd_err_q;

  // Shadow bank (written by commands) and active bank (drives the outputs)
  logic [CNT_W-1:0]        shadow_phase_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] shadow_en_q;
  logic [7:0]              shadow_duty_q;
  logic [CNT_W-1:0]        active_phase_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] active_en_q;
  logic [7:0]              active_duty_q;

  // Period timing
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic                    sync1_q;
  logic                    sync2_q;
  logic                    sync3_q;
  logic                    sync_out_q;
  logic                    period_start_q;
  logic [NUM_CHANNELS-1:0] trans_q;
  logic [NUM_CHANNELS-1:0] trans_d;

  logic            accept;
  logic            sync_edge;
  logic            boundary;
  logic            swap;
  logic            ch_ok;
  logic            ph_ok;
  logic [CH_W-1:0] ch_idx;

  // Input is held off for the whole commit window so the shadow bank stays frozen
  assign s_ready   = !commit_pending_q;
  assign accept    = s_valid && s_ready;

  // A slave restarts its period on a synchronised rising edge of sync_in
  assign sync_edge = (MASTER == 1'b0) && sync2_q && !sync3_q;
  assign boundary  = (cnt_q == CNT_LAST) || sync_edge;
  assign cnt_d     = boundary ? '0 : cnt_q + CNT_ONE;
  assign swap      = boundary && commit_pending_q;

  // Range checks use 9 bits so channel/phase limits up to 256 compare correctly
  assign ch_ok  = {1'b0, ch_q} < NUM_CH_9;
  assign ph_ok  = {1'b0, s_data} < CNT_MAX_9;
  assign ch_idx = ch_q[CH_W-1:0];

  // Command parser: opcode, then up to two argument bytes, writes land in the shadow bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      opcode_q         <= '0;
      ch_q             <= '0;
      commit_pending_q <= 1'b0;
      cmd_err_q        <= 1'b0;
      shadow_en_q      <= '1;
      shadow_duty_q    <= DUTY_RST;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        shadow_phase_q[i] <= '0;
      end
    end else begin
      cmd_err_q <= 1'b0;
      if (swap) begin
        commit_pending_q <= 1'b0;
      end
      if (accept) begin
        case (state_q)
          ST_IDLE: begin
            case (s_data)
              OP_SET_PHASE, OP_SET_EN, OP_SET_DUTY: begin
                opcode_q <= s_data;
                state_q  <= ST_ARG1;
              end
              OP_COMMIT: begin
                commit_pending_q <= 1'b1;
              end
              default: begin
                cmd_err_q <= 1'b1;
              end
            endcase
          end
          ST_ARG1: begin
            if (opcode_q == OP_SET_DUTY) begin
              shadow_duty_q <= s_data;
              state_q       <= ST_IDLE;
            end else begin
              ch_q    <= s_data;
              state_q <= ST_ARG2;
            end
          end
          ST_ARG2: begin
            state_q <= ST_IDLE;
            if (opcode_q == OP_SET_PHASE) begin
              if (ch_ok && ph_ok) begin
                shadow_phase_q[ch_idx] <= s_data[CNT_W-1:0];
              end else begin
                cmd_err_q <= 1'b1;
              end
            end else begin
              if (ch_ok) begin
                shadow_en_q[ch_idx] <= s_data[0];
              end else begin
                cmd_err_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Active bank takes the whole shadow bank at once on a committed period boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_en_q   <= '1;
      active_duty_q <= DUTY_RST;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        active_phase_q[i] <= '0;
      end
    end else if (swap) begin
      active_en_q   <= shadow_en_q;
      active_duty_q <= shadow_duty_q;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        active_phase_q[i] <= shadow_phase_q[i];
      end
    end
  end

  // Two-flop synchroniser plus a third flop for rising-edge detection of sync_in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sync_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Period counter: wraps at CNT_MAX-1 or restarts on a slave sync edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Per-channel phase offset modulo CNT_MAX, compared against the global duty
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    logic [CNT_W:0] diff;
    assign diff = (cnt_q >= active_phase_q[g])
                ? ({1'b0, cnt_q} - {1'b0, active_phase_q[g]})
                : ({1'b0, cnt_q} + CNT_FULL - {1'b0, active_phase_q[g]});
    assign trans_d[g] = active_en_q[g] && (9'(diff) < {1'b0, active_duty_q});
  end

  // Output registers, all one clock behind cnt so period_start lines up with trans for cnt 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trans_q        <= '0;
      period_start_q <= 1'b0;
      sync_out_q     <= 1'b0;
    end else begin
      trans_q        <= trans_d;
      period_start_q <= (cnt_q == '0);
      sync_out_q     <= (cnt_q < CNT_HALF);
    end
  end

  assign trans          = trans_q;
  assign period_start   = period_start_q;
  assign commit_pending = commit_pending_q;
  assign cmd_err        = cmd_err_q;
  assign sync_out       = MASTER ? sync_out_q : sync2_q;

endmodule
